// File: rtl/shift_req_sequencer.sv
// shift_req_sequencer
// Shares one external registered barrel shifter (1-cycle latency, at most
// MAX_SHIFT per pass) among NUM_REQ requesters using round-robin arbitration.
// Each accepted shift is split into passes of at most MAX_SHIFT that are
// chained through the shifter. The final result returns on one valid/ready
// channel, tagged with the id of the requester that issued it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_data          packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_amt           packed total shift amounts, requester i at [i*AMT_W +: AMT_W]
//   req_left          per-requester direction, 1=left, 0=right (zero fill)
//   rsp_valid/ready   result handshake
//   rsp_data, rsp_id  shifted result and originating requester index
//   busy              high whenever the sequencer is not idle
//   sh_data_in, sh_shift_amt, sh_shift_left   drive the external shifter
//   sh_data_out       shifter output, valid one cycle after its inputs
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate and accept one request
// ISSUE | present work and the next chunk to the shifter
// WAIT  | capture shifter output; loop to ISSUE or finish
// RESP  | hold result on the response channel until accepted
module shift_req_sequencer #(
    parameter int WIDTH     = 8,
    parameter int MAX_SHIFT = 4,
    parameter int NUM_REQ   = 2,
    localparam int AMT_W    = $clog2(WIDTH + 1),
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SH_W     = $clog2(MAX_SHIFT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*AMT_W-1:0] req_amt,
    input  logic [NUM_REQ-1:0]       req_left,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    output logic [WIDTH-1:0]         sh_data_in,
    output logic [SH_W-1:0]          sh_shift_amt,
    output logic                     sh_shift_left,
    input  logic [WIDTH-1:0]         sh_data_out
);

    localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] MAX_A   = AMT_W'(MAX_SHIFT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [WIDTH-1:0]  work;
    logic [AMT_W-1:0]  remaining;
    logic              dir;
    logic [ID_W-1:0]   id;

    logic              grant_found;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   rr_next;
    logic [WIDTH-1:0]  sel_data;
    logic [AMT_W-1:0]  sel_amt;
    logic              sel_left;
    logic [AMT_W-1:0]  chunk;
    logic              direct;

    // Round-robin search: indices at or above rr_ptr win first, then wrap
    // around to the low indices.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant       = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant       = ID_W'(i);
            end
        end
    end

    assign rr_next  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
    assign sel_data = req_data[int'(grant)*WIDTH +: WIDTH];
    assign sel_amt  = req_amt[int'(grant)*AMT_W +: AMT_W];
    assign sel_left = req_left[grant];
    // Zero and full-width shifts need no shifter passes at all.
    assign direct   = (sel_amt == '0) || (sel_amt >= WIDTH_A);
    assign chunk    = (remaining > MAX_A) ? MAX_A : remaining;

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        sh_data_in    = '0;
        sh_shift_amt  = '0;
        sh_shift_left = 1'b0;
        busy          = (state != IDLE);
        rsp_valid     = (state == RESP);
        rsp_data      = '0;
        rsp_id        = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = direct ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                sh_data_in    = work;
                sh_shift_amt  = SH_W'(chunk);
                sh_shift_left = dir;
                state_nxt     = WAIT;
            end
            WAIT: begin
                state_nxt = (remaining == '0) ? RESP : ISSUE;
            end
            RESP: begin
                rsp_data = work;
                rsp_id   = id;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            work      <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            id        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        id     <= grant;
                        dir    <= sel_left;
                        rr_ptr <= rr_next;
                        if (sel_amt >= WIDTH_A) begin
                            work      <= '0;
                            remaining <= '0;
                        end else begin
                            work      <= sel_data;
                            remaining <= sel_amt;
                        end
                    end
                end
                ISSUE:   remaining <= remaining - chunk;
                WAIT:    work <= sh_data_out;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_req_sequencer.sv
// tb_shift_req_sequencer
// Directed bench for shift_req_sequencer with WIDTH=8, MAX_SHIFT=4,
// NUM_REQ=2 and a behavioural 1-cycle registered shifter.
module tb_shift_req_sequencer;

    localparam int WIDTH     = 8;
    localparam int MAX_SHIFT = 4;
    localparam int NUM_REQ   = 2;
    localparam int AMT_W     = 4;
    localparam int ID_W      = 1;
    localparam int SH_W      = 3;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ*AMT_W-1:0] req_amt = '0;
    logic [NUM_REQ-1:0]       req_left = '0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     busy;
    logic [WIDTH-1:0]         sh_data_in;
    logic [SH_W-1:0]          sh_shift_amt;
    logic                     sh_shift_left;
    logic [WIDTH-1:0]         sh_data_out = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    int chunk_q[$];

    shift_req_sequencer #(
        .WIDTH(WIDTH), .MAX_SHIFT(MAX_SHIFT), .NUM_REQ(NUM_REQ)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt), .req_left(req_left),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
        .sh_data_in(sh_data_in), .sh_shift_amt(sh_shift_amt),
        .sh_shift_left(sh_shift_left), .sh_data_out(sh_data_out)
    );

    always #5 clk = ~clk;

    // External shifter: registered, one pass per cycle.
    always @(posedge clk)
        sh_data_out <= sh_shift_left ? (sh_data_in << sh_shift_amt) : (sh_data_in >> sh_shift_amt);

    always @(negedge clk) begin
        if (sh_shift_amt != '0) chunk_q.push_back(int'(sh_shift_amt));
        if (busy && req_ready != '0) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [3:0] a, input logic l);
        req_data[i*WIDTH +: WIDTH] = d;
        req_amt[i*AMT_W +: AMT_W]  = a;
        req_left[i]                = l;
        req_valid[i]               = 1'b1;
    endtask

    // Issue one request alone and follow it to completion.
    task automatic single(input string tag, input int i, input logic [7:0] d,
                          input logic [3:0] a, input logic l, input logic [7:0] exp_d,
                          input int exp_lat, input int nch, input int c0, input int c1);
        int n;
        chunk_q.delete();
        rsp_ready = 1'b0;
        set_req(i, d, a, l);
        #1;
        check({tag, "_rdy"}, 32'(req_ready), 32'(1 << i));
        @(posedge clk); #1;
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
        check({tag, "_id"}, 32'(rsp_id), i);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_drop"}, 32'(rsp_valid), 0);
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_npass"}, chunk_q.size(), nch);
        if (nch > 0) check({tag, "_c0"}, chunk_q[0], c0);
        if (nch > 1) check({tag, "_c1"}, chunk_q[1], c1);
    endtask

    initial begin
        int n;
        int seen;
        int g[$];
        int ids[$];
        int datas[$];
        int exp_g[4] = '{0, 1, 0, 1};
        int exp_dat[4] = '{8'h02, 8'h40, 8'h02, 8'h40};

        #2;
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_sh", {sh_data_in, sh_shift_amt, sh_shift_left}, 0);
        check("rst_rsp", {rsp_data, rsp_id}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        single("one_pass", 0, 8'h81, 4'd3, 1'b1, 8'h08, 3, 1, 3, 0);
        single("two_pass", 1, 8'hF0, 4'd7, 1'b0, 8'h01, 5, 2, 4, 3);
        single("amt0",     0, 8'hA5, 4'd0, 1'b1, 8'hA5, 1, 0, 0, 0);
        single("amt8",     1, 8'hFF, 4'd8, 1'b1, 8'h00, 1, 0, 0, 0);
        single("exact4",   0, 8'h0F, 4'd4, 1'b1, 8'hF0, 3, 1, 4, 0);

        // Backpressure: result must hold while rsp_ready stays low.
        set_req(1, 8'h3C, 4'd2, 1'b1);
        #1;
        @(posedge clk); #1;
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_lat", n, 3);
        set_req(0, 8'h55, 4'd1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall_v%0d", k), 32'(rsp_valid), 1);
            check($sformatf("stall_d%0d", k), 32'(rsp_data), 32'h3C << 2 & 32'hFF);
            check($sformatf("stall_id%0d", k), 32'(rsp_id), 1);
            check($sformatf("stall_rdy%0d", k), 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("stall_rel_busy", 32'(busy), 0);
        check("stall_rel_rdy", 32'(req_ready), 32'b01);
        req_valid = '0;
        @(posedge clk); #1;

        // Reset in the middle of a two-pass job.
        set_req(1, 8'hF0, 4'd7, 1'b0);
        #1;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        check("wait_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(rsp_valid), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_ready", 32'(req_ready), 0);
        check("mrst_sh", {sh_data_in, sh_shift_amt, sh_shift_left}, 0);
        check("mrst_rsp", {rsp_data, rsp_id}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("mrst_no_rsp", seen, 0);

        // Both requesters continuously valid: grants alternate from 0.
        set_req(0, 8'h01, 4'd1, 1'b1);
        set_req(1, 8'h80, 4'd1, 1'b0);
        rsp_ready = 1'b1;
        #1;
        n = 0;
        while (ids.size() < 4 && n < 60) begin
            if (req_ready != '0 && g.size() < 4)
                g.push_back(req_ready == 2'b01 ? 0 : (req_ready == 2'b10 ? 1 : 9));
            if (rsp_valid) begin
                ids.push_back(int'(rsp_id));
                datas.push_back(int'(rsp_data));
            end
            @(posedge clk); #1;
            n++;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        check("rr_ngrant", g.size(), 4);
        check("rr_nrsp", ids.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_grant%0d", k), (g.size() > k) ? g[k] : -1, exp_g[k]);
            check($sformatf("rr_id%0d", k), (ids.size() > k) ? ids[k] : -1, exp_g[k]);
            check($sformatf("rr_data%0d", k), (datas.size() > k) ? datas[k] : -1, exp_dat[k]);
        end

        check("ready_while_busy", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_req_sequencer.md
Name: shift_req_sequencer

Overview:
- Shares one registered parallel barrel shifter among NUM_REQ requesters, with round-robin arbitration.
- The shifter shifts at most MAX_SHIFT per pass and has 1-cycle latency; it sits outside this block.
- Each accepted request's shift amount (0..2^AMT_W-1) is split into successive passes of at most MAX_SHIFT, chained through the shifter.
- The final result returns on a single valid/ready response channel, tagged with the requester id.

Parameters:
- WIDTH, 8, data width; must match the shifter.
- MAX_SHIFT, 4, maximum shift per shifter pass; must match the shifter.
- NUM_REQ, 2, number of requesters (≥1).
- AMT_W, $clog2(WIDTH+1), request shift-amount width (derived, localparam).
- ID_W, max(1,$clog2(NUM_REQ)), response id width (derived, localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_data  in  NUM_REQ*WIDTH  packed operands; requester i at [i*WIDTH +: WIDTH].
- req_amt  in  NUM_REQ*AMT_W  packed total shift amounts.
- req_left  in  NUM_REQ  direction: 1=left, 0=right (logical, zero fill).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_data  out  WIDTH  shifted result.
- rsp_id  out  ID_W  index of the originating requester.
- busy  out  1  high whenever state != IDLE.
- sh_data_in  out  WIDTH  operand to the shifter.
- sh_shift_amt  out  $clog2(MAX_SHIFT+1)  per-pass amount to the shifter.
- sh_shift_left  out  1  direction to the shifter.
- sh_data_out  in  WIDTH  shifter registered output, valid 1 cycle after inputs are presented.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr pointer=0, internal work/remaining/id registers=0.
  - All outputs 0: req_ready, rsp_valid, rsp_data, rsp_id, busy, sh_*.
  - Any in-flight request is dropped and never responded to.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is the first i with req_valid[i], searching from the rr pointer upward with wrap.
  - req_ready[grant] is asserted combinationally in the same cycle; all other req_ready bits are 0.
  - On handshake: capture data, amt, dir and id; rr pointer <= grant+1 (mod NUM_REQ).
  - If amt==0: work=data, go to RESP.
  - If amt>=WIDTH: work=0, go to RESP.
  - Otherwise: work=data, remaining=amt, go to ISSUE.
- req_ready is 0 in every state except IDLE, so there is no accept while busy.
- ISSUE:
  - sh_data_in=work, sh_shift_left=dir, sh_shift_amt=min(remaining, MAX_SHIFT).
  - remaining <= remaining - that chunk; go to WAIT.
- WAIT:
  - work <= sh_data_out.
  - If remaining==0, go to RESP; else go to ISSUE.
- Outside ISSUE, sh_data_in, sh_shift_amt and sh_shift_left are driven 0.
- Passes: p = ceil(amt/MAX_SHIFT). Each pass costs 2 cycles (ISSUE+WAIT). Chunk order is MAX_SHIFT,…,MAX_SHIFT,remainder.
- Latency: rsp_valid rises 2p+1 cycles after the accept edge. For the direct cases (amt==0, amt>=WIDTH) it rises 1 cycle after.
- RESP:
  - rsp_valid=1; rsp_data=work and rsp_id=id, both registered.
  - Outputs are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE next cycle, and rsp_valid drops that edge.
  - The earliest next accept is the following IDLE cycle.
- Requesters may drop req_valid without a handshake; nothing is captured in that case.
- Simultaneous valids: exactly one grant per IDLE cycle. With all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- Result equals the single-step logical shift of the operand by amt (truncated to WIDTH). No rotation, no sign fill.

Test Plan (WIDTH=8, MAX_SHIFT=4, NUM_REQ=2, external shifter model with 1-cycle registered output):
- req0 data=0x81 amt=3 left=1 → one pass, sh_shift_amt=3; rsp_data=0x08, rsp_id=0; rsp_valid 3 cycles after accept.
- req1 data=0xF0 amt=7 left=0 → two passes with sh_shift_amt 4 then 3; rsp_data=0x01, rsp_id=1; rsp_valid 5 cycles after accept.
- amt=0 data=0xA5 → rsp_data=0xA5 1 cycle after accept, sh_shift_amt stays 0. Then amt=8 left=1 data=0xFF → rsp_data=0x00 1 cycle after accept.
- Both req_valid held high with rsp_ready=1 → req_ready grants alternate 0,1,0,1; rsp_id sequence matches; req_ready never asserted while busy=1.
- Hold rsp_ready=0 for 3 cycles in RESP → rsp_valid, rsp_data and rsp_id stable, req_ready=0. Release → IDLE next cycle.
- Pulse rst_n low during WAIT of an amt=7 job → all outputs 0 immediately, no response for the job. After reset, with both requesters valid, requester 0 is granted first.
